iter_divider: RTL and testbench

//  Multi-cycle radix-2 integer divider answering the EX stage's divide requests for div.w/mod.w/div.wu/mod.wu.

---
 rtl/iter_divider.sv | 133 +++++++++++++
 tb/tb_iter_divider.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/iter_divider.sv
// Multi-cycle radix-2 restoring divider with independent dividend/divisor valid/ready channels.
// Produces {quotient, remainder} with a one-cycle result strobe WIDTH+1 cycles after capture.
module iter_divider #(
    parameter int unsigned WIDTH  = 32,
    parameter bit          SIGNED = 1'b1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
    input  logic               s_axis_dividend_tvalid,
    output logic               s_axis_dividend_tready,
    input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
    input  logic               s_axis_divisor_tvalid,
    output logic               s_axis_divisor_tready,
    output logic [2*WIDTH-1:0] m_axis_dout_tdata,
    output logic               m_axis_dout_tvalid
);

    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e             state_q, state_d;
    logic               held_a_q, held_a_d, held_b_q, held_b_d;
    logic               rdy_a_q, rdy_a_d, rdy_b_q, rdy_b_d;
    logic [WIDTH-1:0]   opa_q, opa_d, opb_q, opb_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d, dsr_q, dsr_d, rem_q, rem_d;
    logic               qneg_q, qneg_d, rneg_q, rneg_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] dout_q, dout_d;

    logic               acc_a, acc_b;
    logic [WIDTH+1:0]   diff;
    logic               no_borrow;
    logic [WIDTH-1:0]   q_mag, r_mag;

    assign s_axis_dividend_tready = rdy_a_q;
    assign s_axis_divisor_tready  = rdy_b_q;
    assign m_axis_dout_tdata      = dout_q;
    assign m_axis_dout_tvalid     = (state_q == StDone);

    assign acc_a = s_axis_dividend_tvalid & rdy_a_q;
    assign acc_b = s_axis_divisor_tvalid & rdy_b_q;

    // Extra top bit holds the borrow of the (WIDTH+1)-bit trial subtraction.
    assign diff      = {1'b0, rem_q, dvd_q[WIDTH-1]} - {2'b00, dsr_q};
    assign no_borrow = ~diff[WIDTH+1];
    assign q_mag     = {dvd_q[WIDTH-2:0], no_borrow};
    assign r_mag     = no_borrow ? diff[WIDTH-1:0] : {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};

    always_comb begin
        state_d  = state_q;
        held_a_d = held_a_q | acc_a;
        held_b_d = held_b_q | acc_b;
        opa_d    = acc_a ? s_axis_dividend_tdata : opa_q;
        opb_d    = acc_b ? s_axis_divisor_tdata : opb_q;
        dvd_d    = dvd_q;
        dsr_d    = dsr_q;
        rem_d    = rem_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;

        unique case (state_q)
            StIdle: begin
                if (held_a_d && held_b_d) begin
                    state_d = StCalc;
                    dvd_d   = (SIGNED && opa_d[WIDTH-1]) ? -opa_d : opa_d;
                    dsr_d   = (SIGNED && opb_d[WIDTH-1]) ? -opb_d : opb_d;
                    qneg_d  = SIGNED & (opa_d[WIDTH-1] ^ opb_d[WIDTH-1]);
                    rneg_d  = SIGNED & opa_d[WIDTH-1];
                    rem_d   = '0;
                    cnt_d   = CntW'(WIDTH - 1);
                end
            end
            StCalc: begin
                // Quotient bits shift into the vacated low end of the dividend register.
                dvd_d = q_mag;
                rem_d = r_mag;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = StDone;
                    dout_d  = {qneg_q ? -q_mag : q_mag, rneg_q ? -r_mag : r_mag};
                end
            end
            StDone: begin
                state_d  = StIdle;
                held_a_d = 1'b0;
                held_b_d = 1'b0;
            end
            default: state_d = StIdle;
        endcase

        rdy_a_d = (state_d == StIdle) & ~held_a_d;
        rdy_b_d = (state_d == StIdle) & ~held_b_d;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StIdle;
            held_a_q <= 1'b0;
            held_b_q <= 1'b0;
            rdy_a_q  <= 1'b1;
            rdy_b_q  <= 1'b1;
            opa_q    <= '0;
            opb_q    <= '0;
            dvd_q    <= '0;
            dsr_q    <= '0;
            rem_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            cnt_q    <= '0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            held_a_q <= held_a_d;
            held_b_q <= held_b_d;
            rdy_a_q  <= rdy_a_d;
            rdy_b_q  <= rdy_b_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            dvd_q    <= dvd_d;
            dsr_q    <= dsr_d;
            rem_q    <= rem_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider: a signed and an unsigned copy share the same operand streams.
module tb_iter_divider;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] dvd_data = '0;
    logic        dvd_valid = 1'b0;
    logic [31:0] dsr_data = '0;
    logic        dsr_valid = 1'b0;

    logic        s_dvd_rdy, s_dsr_rdy, s_tv;
    logic [63:0] s_dout;
    logic        u_dvd_rdy, u_dsr_rdy, u_tv;
    logic [63:0] u_dout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    iter_divider #(.WIDTH(32), .SIGNED(1'b1)) u_sdiv (
        .clk                    (clk),
        .resetn                 (resetn),
        .s_axis_dividend_tdata  (dvd_data),
        .s_axis_dividend_tvalid (dvd_valid),
        .s_axis_dividend_tready (s_dvd_rdy),
        .s_axis_divisor_tdata   (dsr_data),
        .s_axis_divisor_tvalid  (dsr_valid),
        .s_axis_divisor_tready  (s_dsr_rdy),
        .m_axis_dout_tdata      (s_dout),
        .m_axis_dout_tvalid     (s_tv)
    );

    iter_divider #(.WIDTH(32), .SIGNED(1'b0)) u_udiv (
        .clk                    (clk),
        .resetn                 (resetn),
        .s_axis_dividend_tdata  (dvd_data),
        .s_axis_dividend_tvalid (dvd_valid),
        .s_axis_dividend_tready (u_dvd_rdy),
        .s_axis_divisor_tdata   (dsr_data),
        .s_axis_divisor_tvalid  (dsr_valid),
        .s_axis_divisor_tready  (u_dsr_rdy),
        .m_axis_dout_tdata      (u_dout),
        .m_axis_dout_tvalid     (u_tv)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full operation with both operands presented in the same cycle.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp_s, input logic [63:0] exp_u);
        int lat;
        @(negedge clk);
        dvd_data  = a;
        dsr_data  = b;
        dvd_valid = 1'b1;
        dsr_valid = 1'b1;
        @(negedge clk);
        dvd_valid = 1'b0;
        dsr_valid = 1'b0;
        check({tag, " busy readys"}, {60'd0, s_dvd_rdy, s_dsr_rdy, u_dvd_rdy, u_dsr_rdy}, 64'd0);
        lat = 1;
        while (!s_tv && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'd33);
        check({tag, " both valid"}, {62'd0, s_tv, u_tv}, 64'd3);
        check({tag, " signed result"}, s_dout, exp_s);
        check({tag, " unsigned result"}, u_dout, exp_u);
        @(negedge clk);
        check({tag, " strobe width"}, {62'd0, s_tv, u_tv}, 64'd0);
        check({tag, " readys back"}, {60'd0, s_dvd_rdy, s_dsr_rdy, u_dvd_rdy, u_dsr_rdy}, 64'hF);
        check({tag, " result held"}, s_dout, exp_s);
    endtask

    initial begin
        int n;
        int strobes;
        int bad;
        int first_at;
        logic prev_tv;

        // Reset state
        #12;
        check("reset valid", {62'd0, s_tv, u_tv}, 64'd0);
        check("reset sdata", s_dout, 64'd0);
        check("reset udata", u_dout, 64'd0);
        check("reset readys", {60'd0, s_dvd_rdy, s_dsr_rdy, u_dvd_rdy, u_dsr_rdy}, 64'hF);
        @(negedge clk);
        resetn = 1'b1;

        // Back-to-back: both valids held high continuously
        @(negedge clk);
        dvd_data  = 32'd50;
        dsr_data  = 32'd8;
        dvd_valid = 1'b1;
        dsr_valid = 1'b1;
        strobes  = 0;
        bad      = 0;
        n        = 0;
        first_at = 0;
        prev_tv  = 1'b0;
        while (strobes < 3 && n < 150) begin
            @(negedge clk);
            n++;
            if (u_tv !== s_tv) bad++;
            if (s_tv) begin
                strobes++;
                if (strobes == 1) first_at = n;
                if (prev_tv) bad++;
                if (s_dout !== {32'd6, 32'd2} || u_dout !== {32'd6, 32'd2}) bad++;
            end else if (strobes > 0) begin
                if (s_dout !== {32'd6, 32'd2} || u_dout !== {32'd6, 32'd2}) bad++;
            end
            prev_tv = s_tv;
        end
        check("b2b strobe count", 64'(strobes), 64'd3);
        check("b2b first latency", 64'(first_at), 64'd33);
        check("b2b stability", 64'(bad), 64'd0);
        dvd_valid = 1'b0;
        dsr_valid = 1'b0;
        resetn    = 1'b0;
        @(negedge clk);
        check("re-reset data", s_dout, 64'd0);
        resetn = 1'b1;

        // Directed vectors
        do_op("7/2", 32'd7, 32'd2, {32'd3, 32'd1}, {32'd3, 32'd1});
        do_op("-7/2", 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFD, 32'hFFFFFFFF}, {32'h7FFFFFFC, 32'd1});
        do_op("7/-2", 32'd7, 32'hFFFFFFFE, {32'hFFFFFFFD, 32'd1}, {32'd0, 32'd7});
        do_op("ovf", 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'd0}, {32'd0, 32'h80000000});
        do_op("5/0", 32'd5, 32'd0, {32'hFFFFFFFF, 32'd5}, {32'hFFFFFFFF, 32'd5});
        do_op("-5/0", 32'hFFFFFFFB, 32'd0, {32'd1, 32'hFFFFFFFB}, {32'hFFFFFFFF, 32'hFFFFFFFB});
        do_op("-100/-7", 32'hFFFFFF9C, 32'hFFFFFFF9, {32'd14, 32'hFFFFFFFE},
              {32'd0, 32'hFFFFFF9C});

        // Split handshake: dividend cycle 0, divisor cycle 4
        @(negedge clk);
        dvd_data  = 32'd20;
        dvd_valid = 1'b1;
        @(negedge clk);
        n = 1;
        check("split dvd ready low", {62'd0, s_dvd_rdy, u_dvd_rdy}, 64'd0);
        check("split dsr ready high", {62'd0, s_dsr_rdy, u_dsr_rdy}, 64'd3);
        dvd_data = 32'd999;
        repeat (3) begin
            @(negedge clk);
            n++;
        end
        dsr_data  = 32'd6;
        dsr_valid = 1'b1;
        @(negedge clk);
        n++;
        dvd_valid = 1'b0;
        dsr_valid = 1'b0;
        while (!s_tv && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("split latency", 64'(n), 64'd37);
        check("split sresult", s_dout, {32'd3, 32'd2});
        check("split uresult", u_dout, {32'd3, 32'd2});

        // Reset in the middle of a calculation
        @(negedge clk);
        dvd_data  = 32'd1000;
        dsr_data  = 32'd3;
        dvd_valid = 1'b1;
        dsr_valid = 1'b1;
        @(negedge clk);
        dvd_valid = 1'b0;
        dsr_valid = 1'b0;
        repeat (9) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("midrst valid", {62'd0, s_tv, u_tv}, 64'd0);
        check("midrst sdata", s_dout, 64'd0);
        check("midrst udata", u_dout, 64'd0);
        check("midrst readys", {60'd0, s_dvd_rdy, s_dsr_rdy, u_dvd_rdy, u_dsr_rdy}, 64'hF);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (s_tv || u_tv) bad++;
        end
        check("midrst no strobe", 64'(bad), 64'd0);
        do_op("100/7", 32'd100, 32'd7, {32'd14, 32'd2}, {32'd14, 32'd2});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
